// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the video timing generator: vertical mode enum,
// effective vertical limit record and the function that derives it.
package video_timing_pkg;

   typedef enum logic {
      VM_NTSC = 1'b0,
      VM_PAL  = 1'b1
   } vmode_t;

   localparam int DEF_H_ACTIVE = 320;
   localparam int DEF_H_FP     = 8;
   localparam int DEF_H_SYNC   = 32;
   localparam int DEF_H_BP     = 24;
   localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int LIM_W = 16;

   // Vertical decode points for one (mode, scandouble) combination, in output lines.
   typedef struct packed {
      logic [LIM_W-1:0] active;
      logic [LIM_W-1:0] sync_first;
      logic [LIM_W-1:0] sync_last;
      logic [LIM_W-1:0] total;
   } vlim_t;

   function automatic vlim_t vert_limits(
      input vmode_t mode,
      input logic   dbl,
      input int     v_active,
      input int     fp_n,
      input int     sync_n,
      input int     bp_n,
      input int     fp_p,
      input int     sync_p,
      input int     bp_p
   );
      vlim_t r;
      int    scale;
      int    fp;
      int    sy;
      int    bp;
      int    act;
      scale        = dbl ? 2 : 1;
      fp           = (mode == VM_PAL) ? fp_p   : fp_n;
      sy           = (mode == VM_PAL) ? sync_p : sync_n;
      bp           = (mode == VM_PAL) ? bp_p   : bp_n;
      act          = v_active * scale;
      r.active     = LIM_W'(act);
      r.sync_first = LIM_W'(act + fp * scale);
      r.sync_last  = LIM_W'(act + (fp + sy) * scale - 1);
      r.total      = LIM_W'(act + (fp + sy + bp) * scale);
      return r;
   endfunction

endpackage

// File: rtl/pixel_ce_div.sv
// Pixel clock-enable divider: a one-clock pulse every CE_DIV clocks, or every
// CE_DIV/2 clocks while half is set.
module pixel_ce_div #(
   parameter int CE_DIV = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic half,
   output logic ce
);

   localparam int DIV_W = $clog2(CE_DIV);
   localparam logic [DIV_W-1:0] LAST_FULL = DIV_W'(CE_DIV - 1);
   localparam logic [DIV_W-1:0] LAST_HALF = DIV_W'(CE_DIV / 2 - 1);

   generate
      if (CE_DIV < 2 || (CE_DIV % 2) != 0) begin : g_bad_ce_div
         $error("pixel_ce_div: CE_DIV must be even and at least 2");
      end
   endgenerate

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             ce_q;
   logic             ce_d;
   logic [DIV_W-1:0] last;

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      last  = half ? LAST_HALF : LAST_FULL;
      div_d = (ce_q || div_q == last) ? '0 : div_q + DIV_W'(1);
      ce_d  = (div_d == last);
   end

   // NOTE: state registers use non-blocking assignment so all flops update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q <= '0;
         ce_q  <= 1'b0;
      end else begin
         div_q <= div_d;
         ce_q  <= ce_d;
      end
   end

   assign ce = ce_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised video timing generator: pixel enable, pixel/line counters,
// blanking, sync and frame-start strobe with NTSC/PAL and scandoubled modes.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int CE_DIV   = 8,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = 240,
   parameter int V_FP_N   = 3,
   parameter int V_SYNC_N = 3,
   parameter int V_BP_N   = 16,
   parameter int V_FP_P   = 20,
   parameter int V_SYNC_P = 3,
   parameter int V_BP_P   = 49,
   parameter int SYNC_POL = 1,
   parameter int CNT_W    = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pal,
   input  logic             scandouble,
   output logic             ce_pix,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             line_odd,
   output logic             HBlank,
   output logic             VBlank,
   output logic             HSync,
   output logic             VSync,
   output logic             frame_start
);

   localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT_N  = V_ACTIVE + V_FP_N + V_SYNC_N + V_BP_N;
   localparam int V_TOT_P  = V_ACTIVE + V_FP_P + V_SYNC_P + V_BP_P;
   localparam int V_TOT_MX = 2 * ((V_TOT_N > V_TOT_P) ? V_TOT_N : V_TOT_P);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic             SYNC_ON  = (SYNC_POL != 0);

   generate
      if (H_TOT > (1 << CNT_W) || V_TOT_MX > (1 << CNT_W)) begin : g_bad_cnt_w
         $error("video_timing_gen: CNT_W too narrow for the configured totals");
      end
   endgenerate

   logic             ce;
   logic             in_rst_q;
   vmode_t           mode_q;
   vmode_t           mode_d;
   logic             sd_q;
   logic             sd_d;
   logic             mode_load;
   vlim_t            lim_cur;
   vlim_t            lim_nxt;

   logic [CNT_W-1:0] hcount_q, hcount_d;
   logic [CNT_W-1:0] vcount_q, vcount_d;
   logic             hblank_q, hblank_d;
   logic             vblank_q, vblank_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             line_odd_q, line_odd_d;
   logic             frame_start_q, frame_start_d;

   logic             h_last;
   logic             v_last;
   logic             h_wrap;
   logic             frame_wrap;
   logic [CNT_W-1:0] v_last_val;

   // The divider sees the next mode so a new period starts exactly with pixel (0,0).
   pixel_ce_div #(
      .CE_DIV (CE_DIV)
   ) u_ce_div (
      .clk     (clk),
      .reset_n (reset_n),
      .half    (sd_d),
      .ce      (ce)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_rst_q <= 1'b1;
      end else begin
         in_rst_q <= 1'b0;
      end
   end

   // NOTE: the mode register has no reset value on purpose: it reloads the mode pins on
   // every clock while in_rst_q is set, so reset leaves it holding the requested mode.
   always_ff @(posedge clk) begin
      mode_q <= mode_d;
      sd_q   <= sd_d;
   end

   always_comb begin
      lim_cur    = vert_limits(mode_q, sd_q, V_ACTIVE, V_FP_N, V_SYNC_N, V_BP_N,
                               V_FP_P, V_SYNC_P, V_BP_P);
      v_last_val = CNT_W'(lim_cur.total - LIM_W'(1));
      h_last     = (hcount_q == H_LAST);
      v_last     = (vcount_q == v_last_val);
      h_wrap     = ce && h_last;
      frame_wrap = h_wrap && v_last;

      mode_load  = in_rst_q || frame_wrap;
      mode_d     = mode_load ? (pal ? VM_PAL : VM_NTSC) : mode_q;
      sd_d       = mode_load ? scandouble : sd_q;
      lim_nxt    = vert_limits(mode_d, sd_d, V_ACTIVE, V_FP_N, V_SYNC_N, V_BP_N,
                               V_FP_P, V_SYNC_P, V_BP_P);
   end

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (ce) begin
         hcount_d = h_last ? '0 : hcount_q + CNT_W'(1);
      end
      if (h_wrap) begin
         vcount_d = v_last ? '0 : vcount_q + CNT_W'(1);
      end
   end

   // Decodes use next-state counters and limits so they line up with the counters.
   always_comb begin
      hblank_d      = (hcount_d >= H_ACT_C);
      hsync_d       = (hcount_d >= HS_FIRST && hcount_d <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
      vblank_d      = (vcount_d >= CNT_W'(lim_nxt.active));
      vsync_d       = (vcount_d >= CNT_W'(lim_nxt.sync_first) &&
                       vcount_d <= CNT_W'(lim_nxt.sync_last)) ? SYNC_ON : ~SYNC_ON;
      line_odd_d    = sd_d & vcount_d[0];
      frame_start_d = frame_wrap;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         hblank_q      <= 1'b0;
         vblank_q      <= 1'b0;
         hsync_q       <= ~SYNC_ON;
         vsync_q       <= ~SYNC_ON;
         line_odd_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hblank_q      <= hblank_d;
         vblank_q      <= vblank_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_odd_q    <= line_odd_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign ce_pix      = ce;
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign line_odd    = line_odd_q;
   assign HBlank      = hblank_q;
   assign VBlank      = vblank_q;
   assign HSync       = hsync_q;
   assign VSync       = vsync_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced 16-pixel geometry (NTSC 11 lines,
// PAL 14 lines); a second instance with inverted sync polarity runs in parallel.
module tb_video_timing_gen;

   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          pal = 1'b0;
   logic          scandouble = 1'b0;

   logic          ce_pix, line_odd, HBlank, VBlank, HSync, VSync, frame_start;
   logic [CW-1:0] hcount, vcount;
   logic          ce_pix_n, line_odd_n, HBlank_n, VBlank_n, HSync_n, VSync_n, frame_start_n;
   logic [CW-1:0] hcount_n, vcount_n;

   int n_checks = 0;
   int n_errors = 0;

   video_timing_gen #(
      .CE_DIV(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6),
      .V_FP_N(1), .V_SYNC_N(2), .V_BP_N(2), .V_FP_P(2), .V_SYNC_P(2), .V_BP_P(4),
      .SYNC_POL(1), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pal(pal), .scandouble(scandouble),
      .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount), .line_odd(line_odd),
      .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync), .VSync(VSync),
      .frame_start(frame_start)
   );

   video_timing_gen #(
      .CE_DIV(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6),
      .V_FP_N(1), .V_SYNC_N(2), .V_BP_N(2), .V_FP_P(2), .V_SYNC_P(2), .V_BP_P(4),
      .SYNC_POL(0), .CNT_W(CW)
   ) dut_n (
      .clk(clk), .reset_n(reset_n), .pal(pal), .scandouble(scandouble),
      .ce_pix(ce_pix_n), .hcount(hcount_n), .vcount(vcount_n), .line_odd(line_odd_n),
      .HBlank(HBlank_n), .VBlank(VBlank_n), .HSync(HSync_n), .VSync(VSync_n),
      .frame_start(frame_start_n)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] h;
      logic [7:0] v;
      logic       hb;
      logic       vb;
      logic       hs;
      logic       vs;
   } vec_t;

   vec_t tbl [0:11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_hcount"}, 32'(hcount), 0);
      check({tag, "_vcount"}, 32'(vcount), 0);
      check({tag, "_ce_pix"}, 32'(ce_pix), 0);
      check({tag, "_frame_start"}, 32'(frame_start), 0);
      check({tag, "_line_odd"}, 32'(line_odd), 0);
      check({tag, "_hblank"}, 32'(HBlank), 0);
      check({tag, "_vblank"}, 32'(VBlank), 0);
      check({tag, "_hsync"}, 32'(HSync), 0);
      check({tag, "_vsync"}, 32'(VSync), 0);
      check({tag, "_hsync_pol0"}, 32'(HSync_n), 1);
      check({tag, "_vsync_pol0"}, 32'(VSync_n), 1);
   endtask

   task automatic wait_hv(input int h, input int v);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if (int'(hcount) == h && int'(vcount) == v) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      if (!found) check($sformatf("wait_hv_%0d_%0d_timeout", h, v), 0, 1);
   endtask

   // Runs to the next frame_start and reports what the frame looked like on the way.
   task automatic run_frame(input logic sd_exp, output int n, output int maxv,
                            output int vb_first, output int vs_first, output int vs_last,
                            output int lo_bad);
      bit done;
      done = 1'b0;
      n = 0; maxv = -1; vb_first = -1; vs_first = -1; vs_last = -1; lo_bad = 0;
      for (int k = 0; k < 4000; k++) begin
         tick();
         n++;
         if (frame_start === 1'b1) begin
            done = 1'b1;
            break;
         end
         if (int'(vcount) > maxv) maxv = int'(vcount);
         if (VBlank === 1'b1 && vb_first < 0) vb_first = int'(vcount);
         if (VSync === 1'b1) begin
            if (vs_first < 0) vs_first = int'(vcount);
            vs_last = int'(vcount);
         end
         if (line_odd !== (sd_exp & vcount[0])) lo_bad++;
      end
      if (!done) check("run_frame_timeout", 0, 1);
   endtask

   task automatic ce_period(output int p);
      bit seen;
      p = -1;
      seen = 1'b0;
      for (int k = 0; k < 64; k++) begin
         tick();
         if (ce_pix === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (seen) begin
         for (int k = 1; k <= 64; k++) begin
            tick();
            if (ce_pix === 1'b1) begin
               p = k;
               break;
            end
         end
      end
   endtask

   initial begin
      int n, maxv, vbf, vsf, vsl, lob, p;

      // Expected decodes for NTSC normal mode: HBlank h>=8, HSync h 10..12,
      // VBlank v>=6, VSync v 7..8. Entries are in scan order within one frame.
      tbl[0]  = '{h: 7,  v: 0,  hb: 0, vb: 0, hs: 0, vs: 0};
      tbl[1]  = '{h: 8,  v: 0,  hb: 1, vb: 0, hs: 0, vs: 0};
      tbl[2]  = '{h: 9,  v: 0,  hb: 1, vb: 0, hs: 0, vs: 0};
      tbl[3]  = '{h: 10, v: 0,  hb: 1, vb: 0, hs: 1, vs: 0};
      tbl[4]  = '{h: 12, v: 0,  hb: 1, vb: 0, hs: 1, vs: 0};
      tbl[5]  = '{h: 13, v: 0,  hb: 1, vb: 0, hs: 0, vs: 0};
      tbl[6]  = '{h: 15, v: 5,  hb: 1, vb: 0, hs: 0, vs: 0};
      tbl[7]  = '{h: 0,  v: 6,  hb: 0, vb: 1, hs: 0, vs: 0};
      tbl[8]  = '{h: 0,  v: 7,  hb: 0, vb: 1, hs: 0, vs: 1};
      tbl[9]  = '{h: 5,  v: 8,  hb: 0, vb: 1, hs: 0, vs: 1};
      tbl[10] = '{h: 0,  v: 9,  hb: 0, vb: 1, hs: 0, vs: 0};
      tbl[11] = '{h: 15, v: 10, hb: 1, vb: 1, hs: 0, vs: 0};

      repeat (3) tick();
      check_reset("reset");

      reset_n = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         check($sformatf("ce_start_%0d", i), 32'(ce_pix), 32'((i % 8) == 7));
      end
      check("hcount_after_16", 32'(hcount), 2);

      for (int i = 0; i < 12; i++) begin
         wait_hv(int'(tbl[i].h), int'(tbl[i].v));
         check($sformatf("vec%0d_hblank", i), 32'(HBlank), 32'(tbl[i].hb));
         check($sformatf("vec%0d_vblank", i), 32'(VBlank), 32'(tbl[i].vb));
         check($sformatf("vec%0d_hsync", i), 32'(HSync), 32'(tbl[i].hs));
         check($sformatf("vec%0d_vsync", i), 32'(VSync), 32'(tbl[i].vs));
         check($sformatf("vec%0d_hsync_pol0", i), 32'(HSync_n), 32'(!tbl[i].hs));
         check($sformatf("vec%0d_vsync_pol0", i), 32'(VSync_n), 32'(!tbl[i].vs));
         check($sformatf("vec%0d_line_odd", i), 32'(line_odd), 0);
      end

      // Frame wrap from (15,10): 8 clocks to the (0,0) strobe, then one full frame.
      run_frame(1'b0, n, maxv, vbf, vsf, vsl, lob);
      check("wrap_clocks", 32'(n), 8);
      check("wrap_hcount", 32'(hcount), 0);
      check("wrap_vcount", 32'(vcount), 0);
      check("wrap_hblank", 32'(HBlank), 0);
      check("wrap_vblank", 32'(VBlank), 0);
      run_frame(1'b0, n, maxv, vbf, vsf, vsl, lob);
      check("ntsc_frame_clocks", 32'(n), 1408);
      check("ntsc_max_vcount", 32'(maxv), 10);

      // PAL requested mid-frame: current frame keeps NTSC length.
      wait_hv(0, 3);
      pal = 1'b1;
      run_frame(1'b0, n, maxv, vbf, vsf, vsl, lob);
      check("pal_pending_max_vcount", 32'(maxv), 10);
      check("pal_pending_vsync_last", 32'(vsl), 8);
      run_frame(1'b0, n, maxv, vbf, vsf, vsl, lob);
      check("pal_frame_clocks", 32'(n), 1792);
      check("pal_max_vcount", 32'(maxv), 13);
      check("pal_vblank_first", 32'(vbf), 6);
      check("pal_vsync_first", 32'(vsf), 8);
      check("pal_vsync_last", 32'(vsl), 9);

      // Scandouble (and back to NTSC) requested mid-frame.
      wait_hv(0, 4);
      scandouble = 1'b1;
      pal = 1'b0;
      ce_period(p);
      check("sd_pending_ce_period", 32'(p), 8);
      run_frame(1'b0, n, maxv, vbf, vsf, vsl, lob);
      check("sd_pending_max_vcount", 32'(maxv), 13);
      check("sd_pending_line_odd", 32'(lob), 0);
      run_frame(1'b1, n, maxv, vbf, vsf, vsl, lob);
      check("sd_frame_clocks", 32'(n), 1408);
      check("sd_max_vcount", 32'(maxv), 21);
      check("sd_vblank_first", 32'(vbf), 12);
      check("sd_vsync_first", 32'(vsf), 14);
      check("sd_vsync_last", 32'(vsl), 17);
      check("sd_line_odd", 32'(lob), 0);
      ce_period(p);
      check("sd_ce_period", 32'(p), 4);

      // Asynchronous reset mid-line, mode pins changed while reset is held.
      wait_hv(10, 7);
      check("pre_reset_line_odd", 32'(line_odd), 1);
      check("pre_reset_hsync", 32'(HSync), 1);
      #3;
      reset_n = 1'b0;
      #1;
      check_reset("async_reset");
      scandouble = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         check($sformatf("rst_ce_%0d", i), 32'(ce_pix), 32'(i == 7));
         check($sformatf("rst_fs_%0d", i), 32'(frame_start), 0);
      end
      check("rst_hcount", 32'(hcount), 1);
      check("rst_vcount", 32'(vcount), 0);
      run_frame(1'b0, n, maxv, vbf, vsf, vsl, lob);
      check("rst_first_frame_clocks", 32'(n), 1400);
      check("rst_first_frame_max_vcount", 32'(maxv), 10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised video timing generator for the arcade core's video path. It is the successor to the core's fixed-timing pixel/sync generator. It derives the pixel clock-enable from `clk` and produces pixel/line counters, blanking, sync and a frame-start strobe. It supports NTSC/PAL vertical modes and a scandoubled (31 kHz) variant. Mode changes are applied only at frame boundaries. It sits between the system clock domain and the game video pipeline and the `VGA_*` outputs of `emu`.

## Interface
Parameters:
- `CE_DIV`, 8: clocks per pixel in normal mode. Must be even and ≥ 2 (elaboration-time check).
- `H_ACTIVE`, 320: active pixels per line.
- `H_FP` / `H_SYNC` / `H_BP`, 8 / 32 / 24: horizontal porches and sync width, in pixels. Line total is 384.
- `V_ACTIVE`, 240: active lines.
- `V_FP_N` / `V_SYNC_N` / `V_BP_N`, 3 / 3 / 16: NTSC vertical timing. Total 262 lines.
- `V_FP_P` / `V_SYNC_P` / `V_BP_P`, 20 / 3 / 49: PAL vertical timing. Total 312 lines.
- `SYNC_POL`, 1: 1 = syncs active-high, 0 = active-low.
- `CNT_W`, 10: counter width. Must hold every total, including doubled vertical totals.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `pal` in 1: 0 = NTSC vertical timing, 1 = PAL. Sampled at frame boundary.
- `scandouble` in 1: 1 = halve the pixel period and double every vertical quantity. Sampled at frame boundary.
- `ce_pix` out 1: one-clock pixel enable.
- `hcount` out CNT_W: current pixel, 0..H_TOTAL-1.
- `vcount` out CNT_W: current output line, 0..V_TOTAL_eff-1.
- `line_odd` out 1: vcount[0] in scandouble mode, otherwise 0.
- `HBlank`, `VBlank` out 1: blanking, active-high.
- `HSync`, `VSync` out 1: sync, polarity per `SYNC_POL`.
- `frame_start` out 1: one-clock pulse on the first clock of pixel (0,0).

## Operation
- Divider `div` counts 0..D-1, then wraps. D = CE_DIV in normal mode, CE_DIV/2 in scandouble mode.
- `ce_pix` = (div == D-1). It is high on the last clock of each pixel.
- On each edge with `ce_pix` = 1:
  - `hcount` increments and wraps from H_TOTAL-1 to 0.
  - On the hcount wrap, `vcount` increments and wraps from V_TOTAL_eff-1 to 0.
- Effective vertical values (`V_*_eff`):
  - NTSC or PAL set, selected by the latched `pal`.
  - In scandouble mode, every vertical value (active, porches, sync, total) is ×2.
- Decodes, all registered and aligned with the counters:
  - HBlank = hcount ≥ H_ACTIVE.
  - HSync active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - VBlank = vcount ≥ V_ACTIVE_eff.
  - VSync active for vcount in [V_ACTIVE_eff+V_FP_eff, V_ACTIVE_eff+V_FP_eff+V_SYNC_eff-1].
- Mode latch:
  - `pal` and `scandouble` are captured only on the edge where (hcount, vcount) wraps to (0,0).
  - Changes mid-frame have no effect on the current frame.
  - The new divider period D takes effect starting with pixel (0,0).
- `frame_start` is high for exactly the first clock of pixel (0,0). It is not asserted on the first frame after reset.

## Timing
- Reset (async assert, reset_n = 0):
  - div = 0, hcount = 0, vcount = 0, ce_pix = 0, frame_start = 0, line_odd = 0.
  - HBlank = 0, VBlank = 0.
  - HSync = VSync = inactive level (!SYNC_POL).
  - Mode latch = (pal, scandouble) sampled while in reset.
- First `ce_pix` occurs on the D-th clock after reset_n deasserts (clock index D-1). After that, the period is exactly D clocks.
- Latency: counter and decode outputs change on the same edge that consumes `ce_pix`, so they are stable for a whole pixel period.
- A scandouble/pal change and a frame wrap on the same edge: the new mode applies to the frame starting at that edge.
- Reset asserted mid-frame: all outputs return to their reset values immediately. The mode latch is re-sampled.

## Structure
- Shared package `video_timing_pkg`:
  - `typedef enum {VM_NTSC, VM_PAL} vmode_t`.
  - Function computing effective vertical limits from (mode, scandouble).
  - Localparam H_TOTAL.
- One sub-module, `pixel_ce_div`: the divider with runtime half-rate select. Ports: `clk`, `reset_n`, `half`, `ce`.

## Test plan
- Defaults, NTSC, no scandouble, reset released at cycle 0:
  - ce_pix first at cycle 7, then every 8 clocks.
  - hcount goes 383→0 with vcount +1.
  - frame_start pulses are 804,864 clocks apart.
- Decode boundaries, NTSC:
  - HBlank rises at hcount 320.
  - HSync is high for hcount 328..359 only.
  - VBlank for vcount 240..261.
  - VSync for vcount 243..245.
- PAL toggled at vcount 100:
  - Current frame still ends at line 261.
  - Next frame has 312 lines, with VSync on lines 260..262.
- Scandouble set mid-frame:
  - Unchanged until the wrap.
  - Then ce_pix period is 4, V total is 524, VBlank from 480, VSync on 486..491, and line_odd toggles every line.
- reset_n pulsed low at hcount 200, vcount 150:
  - All outputs return to reset values asynchronously.
  - After release, the first ce_pix arrives 8 clocks later and counting resumes from (0,0).
- SYNC_POL = 0: HSync/VSync are exactly the inverse of the SYNC_POL = 1 run, and the reset level is 1.
